// File: rtl/sram_byte_port_if.sv
// sram_byte_port_if: byte command handshake and read-return bundle for sram_byte_port
interface sram_byte_port_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, rd_valid, rd_data);
  modport slave (input cmd_valid, cmd_op, cmd_data, output cmd_ready, rd_valid, rd_data);
endinterface

// File: rtl/sram_byte_port.sv
// sram_byte_port: byte-wide auto-incrementing access port onto a 1rw word SRAM macro.
// Define SRAM_BYTE_PORT_STATS_EN to add saturating write/read counters readable via ops 4/5.
module sram_byte_port #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_byte_port_if.slave         bus,
  output logic                    busy,
  output logic                    ram_clk0,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [DATA_BYTES-1:0]   ram_wmask0,
  output logic [ADDR_W-1:0]       ram_addr0,
  output logic [8*DATA_BYTES-1:0] ram_din0,
  input  logic [8*DATA_BYTES-1:0] ram_dout0
);
  localparam int LW = $clog2(DATA_BYTES);
  localparam int BPTR_W = ADDR_W + LW;
  localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD_ISSUE = 2'd2, RD_CAP = 2'd3;
  logic [1:0]        state;
  logic [BPTR_W-1:0] ptr;
  logic [LW-1:0]     lane, lane_q;
  logic [7:0]        wbyte, cap_byte;
  logic              accept;
  assign lane = ptr[LW-1:0];
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign busy = state != IDLE;
  assign ram_clk0 = clk;
  assign ram_csb0 = !(state == WR || state == RD_ISSUE);
  assign ram_web0 = state != WR;
  assign ram_wmask0 = state == WR ? DATA_BYTES'(1) << lane : '0;
  assign ram_addr0 = ptr[BPTR_W-1:LW];
  assign ram_din0 = state == WR ? (8*DATA_BYTES)'(wbyte) << {lane, 3'b000} : '0;
`ifdef SRAM_BYTE_PORT_STATS_EN
  logic [1:0] src_q;
  logic [7:0] wcnt, rcnt;
  assign cap_byte = src_q == 2'd1 ? wcnt : src_q == 2'd2 ? rcnt : ram_dout0[{lane_q, 3'b000} +: 8];
  // src_q tags what the next RD_CAP returns; only RAM reads count toward rcnt
  always_ff @(posedge clk)
    if (rst) begin
      src_q <= 2'd0;
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      if (accept) src_q <= bus.cmd_op == 3'd4 ? 2'd1 : bus.cmd_op == 3'd5 ? 2'd2 : 2'd0;
      if (accept && bus.cmd_op == 3'd6) begin
        wcnt <= '0;
        rcnt <= '0;
      end
      if (state == WR && wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
      if (state == RD_CAP && src_q == 2'd0 && rcnt != 8'hFF) rcnt <= rcnt + 8'd1;
    end
`else
  assign cap_byte = ram_dout0[{lane_q, 3'b000} +: 8];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      lane_q <= '0;
      wbyte <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (accept)
        case (bus.cmd_op)
          3'd0: ptr <= (ptr & ~BPTR_W'(8'hFF)) | BPTR_W'(bus.cmd_data);
          3'd1: ptr <= (BPTR_W'(bus.cmd_data) << 8) | (ptr & BPTR_W'(8'hFF));
          3'd2: begin
            wbyte <= bus.cmd_data;
            state <= WR;
          end
          3'd3: state <= RD_ISSUE;
`ifdef SRAM_BYTE_PORT_STATS_EN
          3'd4, 3'd5: state <= RD_CAP;
`endif
          default: ;
        endcase
      case (state)
        WR: begin
          ptr <= ptr + 1'b1;
          state <= IDLE;
        end
        RD_ISSUE: begin
          lane_q <= lane;
          ptr <= ptr + 1'b1;
          state <= RD_CAP;
        end
        RD_CAP: begin
          bus.rd_data <= cap_byte;
          bus.rd_valid <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
    end
endmodule
